msr_shift_engine: RTL and testbench

//   Parametrised multi-mode shift/rotate register with a step sequencer. A start

---
 rtl/msr_pkg.sv | 56 +++++
 rtl/msr_shift_engine.sv | 100 ++++++++++
 tb/tb_msr_shift_engine.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/msr_pkg.sv
// Shared types and the single-step shift/rotate datapath for msr_shift_engine.
// msr_step works on a MSR_MAX_W-wide container; the live register occupies the low w bits.
package msr_pkg;

   localparam int unsigned MSR_MAX_W = 64;

   typedef enum logic [2:0] {
      MSR_HOLD = 3'b000,
      MSR_SHR  = 3'b001,
      MSR_ROR  = 3'b010,
      MSR_SHR2 = 3'b011,
      MSR_SHL  = 3'b100,
      MSR_ROL  = 3'b101,
      MSR_ASR  = 3'b110,
      MSR_LOAD = 3'b111
   } msr_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } msr_state_e;

   // Returns {sout, q_next}. Bits of q at or above w must be zero and stay zero.
   // HOLD and LOAD return q unchanged; the caller owns the LOAD path and sout retention.
   function automatic logic [MSR_MAX_W:0] msr_step(input logic [MSR_MAX_W-1:0] q,
                                                    input logic s_in,
                                                    input msr_mode_e mode,
                                                    input int unsigned w);
      logic [MSR_MAX_W-1:0] one;
      logic [MSR_MAX_W-1:0] top;
      logic [MSR_MAX_W-1:0] all_m;
      logic [MSR_MAX_W-1:0] fill;
      logic [MSR_MAX_W-1:0] nq;
      logic                 msb;
      logic                 so;
      one   = {{(MSR_MAX_W-1){1'b0}}, 1'b1};
      top   = one << (w - 1);
      all_m = ~({MSR_MAX_W{1'b1}} << w);
      fill  = s_in ? top : '0;
      msb   = |(q & top);
      nq    = q;
      so    = 1'b0;
      case (mode)
         MSR_SHR:  begin nq = (q >> 1) | fill;                         so = q[0]; end
         MSR_ROR:  begin nq = (q >> 1) | (q[0] ? top : '0);            so = q[0]; end
         MSR_SHR2: begin nq = (q >> 2) | fill | (fill >> 1);           so = q[1]; end
         MSR_SHL:  begin nq = ((q << 1) | (s_in ? one : '0)) & all_m;  so = msb;  end
         MSR_ROL:  begin nq = ((q << 1) | (msb ? one : '0)) & all_m;   so = msb;  end
         MSR_ASR:  begin nq = (q >> 1) | (msb ? top : '0);             so = q[0]; end
         default:  begin nq = q;                                       so = 1'b0; end
      endcase
      return {so, nq};
   endfunction

endpackage

// File: rtl/msr_shift_engine.sv
// Multi-mode shift/rotate register stepped by an IDLE/RUN/DONE sequencer.
// WIDTH must lie in 2..MSR_MAX_W; state is exported for observation.
module msr_shift_engine
   import msr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             Re,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [AMT_W-1:0] amount,
   input  logic [WIDTH-1:0] ld_data,
   input  logic             sIn,
   output logic [WIDTH-1:0] Q,
   output logic             sOut,
   output logic             busy,
   output logic             done,
   output msr_state_e       state
);

   // Handshake: start is honoured only on an edge where state==IDLE; busy is high
   // exactly while steps remain, and done pulses for one cycle when they are exhausted.

   logic [MSR_MAX_W-1:0] q_full;
   logic [MSR_MAX_W-1:0] ld_ext;
   logic [MSR_MAX_W:0]   step_res;
   logic [WIDTH-1:0]     ld_q;
   logic [AMT_W-1:0]     count;
   msr_mode_e            mode_q;

   always_comb begin
      ld_ext              = '0;
      ld_ext[WIDTH-1:0]   = ld_q;
      step_res            = msr_step(q_full, sIn, mode_q, WIDTH);
   end

   assign Q = q_full[WIDTH-1:0];

   always_ff @(posedge clk or negedge Re) begin
      if (!Re) begin
         q_full <= '0;
         ld_q   <= '0;
         count  <= '0;
         mode_q <= MSR_HOLD;
         sOut   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         state  <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  mode_q <= msr_mode_e'(mode);
                  ld_q   <= ld_data;
                  // LOAD always runs one step, even when amount is zero.
                  if (msr_mode_e'(mode) == MSR_LOAD) begin
                     count <= AMT_W'(1);
                     busy  <= 1'b1;
                     state <= ST_RUN;
                  end else if (amount == '0 || msr_mode_e'(mode) == MSR_HOLD) begin
                     count <= '0;
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     count <= amount;
                     busy  <= 1'b1;
                     state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (mode_q == MSR_LOAD) begin
                  q_full <= ld_ext;
               end else begin
                  q_full <= step_res[MSR_MAX_W-1:0];
                  sOut   <= step_res[MSR_MAX_W];
               end
               count <= count - 1'b1;
               if (count == AMT_W'(1)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_msr_shift_engine.sv
// Directed table-driven bench for msr_shift_engine (WIDTH=8, AMT_W=4).
module tb_msr_shift_engine;
   import msr_pkg::*;

   logic       clk;
   logic       Re;
   logic       start;
   logic [2:0] mode;
   logic [3:0] amount;
   logic [7:0] ld_data;
   logic       sIn;
   logic [7:0] Q;
   logic       sOut;
   logic       busy;
   logic       done;
   msr_state_e state;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [2:0] mode;
      logic [3:0] amt;
      logic [7:0] ld;
      logic       si;
      int         restart;
      logic [7:0] exp_q;
      logic       exp_so;
      int         exp_busy;
   } vec_t;

   vec_t vecs[18];

   msr_shift_engine #(.WIDTH(8), .AMT_W(4)) dut (
      .clk(clk), .Re(Re), .start(start), .mode(mode), .amount(amount),
      .ld_data(ld_data), .sIn(sIn), .Q(Q), .sOut(sOut), .busy(busy),
      .done(done), .state(state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Launches one operation, optionally pulses a second start restart_at samples later,
   // counts busy/done samples until done, then checks the cycle after done.
   task automatic run_op(input string name, input logic [2:0] m, input logic [3:0] a,
                         input logic [7:0] ld, input logic si, input int restart_at,
                         output int busy_n, output int done_n);
      bit seen;
      @(negedge clk);
      start = 1'b1; mode = m; amount = a; ld_data = ld; sIn = si;
      @(negedge clk);
      start = 1'b0; mode = 3'b111; amount = 4'hF; ld_data = 8'h5A;
      busy_n = 0; done_n = 0; seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (busy) busy_n++;
         if (done) done_n++;
         if (c == restart_at) begin
            start = 1'b1; mode = 3'b111; ld_data = 8'hFF; amount = 4'd1;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
      @(negedge clk);
      start = 1'b0;
      check({name, "_done_len"}, 32'(done), 32'd0);
      check({name, "_idle_after"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int bn;
      int dn;
      vecs[0]  = '{3'b111, 4'd0,  8'hA5, 1'b0, -1, 8'hA5, 1'b0, 1};
      vecs[1]  = '{3'b010, 4'd3,  8'h00, 1'b0, -1, 8'hB4, 1'b1, 3};
      vecs[2]  = '{3'b111, 4'd5,  8'h00, 1'b0, -1, 8'h00, 1'b1, 1};
      vecs[3]  = '{3'b011, 4'd2,  8'h00, 1'b1, -1, 8'hF0, 1'b0, 2};
      vecs[4]  = '{3'b111, 4'd0,  8'h80, 1'b0, -1, 8'h80, 1'b0, 1};
      vecs[5]  = '{3'b110, 4'd9,  8'h00, 1'b0, -1, 8'hFF, 1'b1, 9};
      vecs[6]  = '{3'b100, 4'd0,  8'h00, 1'b1, -1, 8'hFF, 1'b1, 0};
      vecs[7]  = '{3'b000, 4'd4,  8'h00, 1'b0, -1, 8'hFF, 1'b1, 0};
      vecs[8]  = '{3'b100, 4'd3,  8'h00, 1'b0, -1, 8'hF8, 1'b1, 3};
      vecs[9]  = '{3'b101, 4'd12, 8'h00, 1'b0, -1, 8'h8F, 1'b1, 12};
      vecs[10] = '{3'b001, 4'd15, 8'h00, 1'b0, -1, 8'h00, 1'b0, 15};
      vecs[11] = '{3'b111, 4'd0,  8'h3C, 1'b0, -1, 8'h3C, 1'b0, 1};
      vecs[12] = '{3'b100, 4'd1,  8'h00, 1'b1, -1, 8'h79, 1'b0, 1};
      vecs[13] = '{3'b110, 4'd2,  8'h00, 1'b0, -1, 8'h1E, 1'b0, 2};
      vecs[14] = '{3'b111, 4'd0,  8'h01, 1'b0, -1, 8'h01, 1'b0, 1};
      vecs[15] = '{3'b101, 4'd5,  8'h00, 1'b0,  2, 8'h20, 1'b0, 5};
      vecs[16] = '{3'b010, 4'd1,  8'h00, 1'b0,  1, 8'h10, 1'b0, 1};
      vecs[17] = '{3'b001, 4'd1,  8'h00, 1'b1, -1, 8'h88, 1'b0, 1};

      // reset
      Re = 1'b0; start = 1'b0; mode = 3'b000; amount = 4'd0; ld_data = 8'h00; sIn = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_q", 32'(Q), 32'h0);
      check("rst_sout", 32'(sOut), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_state", 32'(state), 32'(ST_IDLE));
      Re = 1'b1;

      for (int i = 0; i < 18; i++) begin
         run_op($sformatf("row%0d", i), vecs[i].mode, vecs[i].amt, vecs[i].ld, vecs[i].si,
                vecs[i].restart, bn, dn);
         check($sformatf("row%0d_busy_cycles", i), 32'(bn), 32'(vecs[i].exp_busy));
         check($sformatf("row%0d_done_pulses", i), 32'(dn), 32'd1);
         check($sformatf("row%0d_q", i), 32'(Q), 32'(vecs[i].exp_q));
         check($sformatf("row%0d_sout", i), 32'(sOut), 32'(vecs[i].exp_so));
      end

      // reset in the middle of a 6-step ROR, after two steps (Q 88 -> 44 -> 22)
      @(negedge clk);
      start = 1'b1; mode = 3'b010; amount = 4'd6; ld_data = 8'h00;
      @(negedge clk);
      start = 1'b0;
      check("midrst_busy_pre", 32'(busy), 32'd1);
      @(negedge clk);
      @(negedge clk);
      check("midrst_q_pre", 32'(Q), 32'h22);
      #2 Re = 1'b0;
      #1;
      check("midrst_q", 32'(Q), 32'h0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_state", 32'(state), 32'(ST_IDLE));
      @(negedge clk);
      Re = 1'b1;
      @(negedge clk);
      check("midrst_stays_idle", 32'(busy), 32'd0);
      run_op("post_rst", 3'b111, 4'd0, 8'hC3, 1'b0, -1, bn, dn);
      check("post_rst_busy_cycles", 32'(bn), 32'd1);
      check("post_rst_done_pulses", 32'(dn), 32'd1);
      check("post_rst_q", 32'(Q), 32'hC3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1, "global timeout");
   end

endmodule
